// File: rtl/adsr_pkg.sv
// -----------------------------------------------------------------------------
// adsr_pkg
// Shared definitions for the gated ADSR envelope sequencer and its helpers:
// phase encodings, default amplitude width / full-scale value, rate width,
// and a small helper that tells whether a phase advances on step ticks.
// -----------------------------------------------------------------------------
package adsr_pkg;

  localparam int AMP_W   = 8;
  localparam int RATE_W  = 8;
  localparam int PHASE_W = 3;

  localparam logic [AMP_W-1:0] AMP_MAX = {AMP_W{1'b1}};

  typedef enum logic [PHASE_W-1:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_e;

  // Only ATTACK, DECAY and RELEASE move the amplitude on rate steps.
  function automatic logic is_step_phase(input phase_e ph);
    logic res;
    case (ph)
      PH_ATTACK, PH_DECAY, PH_RELEASE: res = 1'b1;
      default:                         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/adsr_tick_prescaler.sv
// -----------------------------------------------------------------------------
// adsr_tick_prescaler
// Free-running divider: asserts tick_o once every tick_div_i+1 clocks.
// tick_div_i = 0 gives a tick on every clock.
// Ports:
//   clk_i       system clock
//   reset_i     synchronous, active-high reset (counter -> 0)
//   tick_div_i  divisor minus one
//   tick_o      one-clock tick, decoded from the counter register
// -----------------------------------------------------------------------------
module adsr_tick_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [PRESC_W-1:0] tick_div_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // A >= compare means lowering tick_div below the running count ticks at
  // once instead of waiting for the counter to wrap all the way around.
  assign tick_o = (cnt_q >= tick_div_i);

  // Next count: clear on tick, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_o) begin
      cnt_d = {PRESC_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= {PRESC_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adsr_gate_controller.sv
// -----------------------------------------------------------------------------
// adsr_gate_controller
// Gate-driven ADSR envelope sequencer feeding the wave*ADSR multiplier.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   gate_i           note gate (high = key held)
//   tick_div_i       step tick every tick_div_i+1 clocks
//   attack_i/decay_i/rel_i  ticks per step minus one (latched on gate rise)
//   sustain_i        sustain level (latched on gate rise)
//   amplitude_o      envelope amplitude
//   phase_o          0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//   active_o         phase != IDLE
//   done_o           one-clock pulse on RELEASE -> IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module adsr_gate_controller
  import adsr_pkg::*;
#(
  parameter int AMP_W   = adsr_pkg::AMP_W,
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               gate_i,
  input  logic [PRESC_W-1:0] tick_div_i,
  input  logic [RATE_W-1:0]  attack_i,
  input  logic [RATE_W-1:0]  decay_i,
  input  logic [AMP_W-1:0]   sustain_i,
  input  logic [RATE_W-1:0]  rel_i,
  output logic [AMP_W-1:0]   amplitude_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               active_o,
  output logic               done_o
);

  localparam logic [AMP_W-1:0] AMP_FULL = {AMP_W{1'b1}};

  logic               tick_s;
  logic               rise_s, fall_s, step_s;
  logic [RATE_W-1:0]  rate_s;
  logic [AMP_W:0]     amp_inc_s, amp_dec_s;

  logic               gate_prev_q;
  phase_e             phase_q, phase_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic [RATE_W-1:0]  step_cnt_q, step_cnt_d;
  logic [RATE_W-1:0]  attack_l_q, attack_l_d, decay_l_q, decay_l_d, rel_l_q, rel_l_d;
  logic [AMP_W-1:0]   sustain_l_q, sustain_l_d;
  logic               active_q, done_q, done_d;

  adsr_tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .tick_div_i (tick_div_i),
    .tick_o     (tick_s)
  );

  assign rise_s    = gate_i & ~gate_prev_q;
  assign fall_s    = ~gate_i & gate_prev_q;
  // One extra bit so the saturation compares cannot wrap.
  assign amp_inc_s = {1'b0, amp_q} + {{AMP_W{1'b0}}, 1'b1};
  assign amp_dec_s = {1'b0, amp_q} - {{AMP_W{1'b0}}, 1'b1};

  // Per-phase rate select and step strobe.
  always_comb begin
    rate_s = {RATE_W{1'b0}};
    case (phase_q)
      PH_ATTACK:  rate_s = attack_l_q;
      PH_DECAY:   rate_s = decay_l_q;
      PH_RELEASE: rate_s = rel_l_q;
      default:    rate_s = {RATE_W{1'b0}};
    endcase
    step_s = tick_s & (step_cnt_q == rate_s);
  end

  // Next-state logic: parameter latches, phase, amplitude, step counter, done.
  always_comb begin
    phase_d     = phase_q;
    amp_d       = amp_q;
    done_d      = 1'b0;
    attack_l_d  = attack_l_q;
    decay_l_d   = decay_l_q;
    sustain_l_d = sustain_l_q;
    rel_l_d     = rel_l_q;
    step_cnt_d  = step_cnt_q;

    if (rise_s) begin
      attack_l_d  = attack_i;
      decay_l_d   = decay_i;
      sustain_l_d = sustain_i;
      rel_l_d     = rel_i;
    end else begin
      attack_l_d  = attack_l_q;
    end

    // Edges win over completion, completion over stepping. A rise in any
    // phase (re)starts ATTACK from the current amplitude, so there is no dip.
    case (phase_q)
      PH_IDLE: begin
        amp_d = {AMP_W{1'b0}};
        if (rise_s) phase_d = PH_ATTACK;
        else        phase_d = PH_IDLE;
      end
      PH_ATTACK: begin
        if (rise_s)                  phase_d = PH_ATTACK;
        else if (fall_s)             phase_d = PH_RELEASE;
        else if (amp_q == AMP_FULL)  phase_d = PH_DECAY;
        else if (step_s) begin
          amp_d = amp_inc_s[AMP_W-1:0];
          if (amp_inc_s == {1'b0, AMP_FULL}) phase_d = PH_DECAY;
          else                               phase_d = PH_ATTACK;
        end else begin
          phase_d = PH_ATTACK;
        end
      end
      PH_DECAY: begin
        if (rise_s)                      phase_d = PH_ATTACK;
        else if (fall_s)                 phase_d = PH_RELEASE;
        else if (amp_q <= sustain_l_q)   phase_d = PH_SUSTAIN;
        else if (step_s)                 amp_d = amp_dec_s[AMP_W-1:0];
        else                             phase_d = PH_DECAY;
      end
      PH_SUSTAIN: begin
        amp_d = sustain_l_q;
        if (rise_s) begin
          phase_d = PH_ATTACK;
          amp_d   = amp_q;
        end else if (fall_s) begin
          phase_d = PH_RELEASE;
          amp_d   = amp_q;
        end else begin
          phase_d = PH_SUSTAIN;
        end
      end
      PH_RELEASE: begin
        if (rise_s)                          phase_d = PH_ATTACK;
        else if (amp_q == {AMP_W{1'b0}}) begin
          phase_d = PH_IDLE;
          done_d  = 1'b1;
        end else if (step_s)                 amp_d = amp_dec_s[AMP_W-1:0];
        else                                 phase_d = PH_RELEASE;
      end
      default: begin
        phase_d = PH_IDLE;
        amp_d   = {AMP_W{1'b0}};
      end
    endcase

    // Step counter restarts on any phase change, including ATTACK retrigger.
    if (rise_s || (phase_d != phase_q)) begin
      step_cnt_d = {RATE_W{1'b0}};
    end else if (tick_s && is_step_phase(phase_q)) begin
      if (step_s) step_cnt_d = {RATE_W{1'b0}};
      else        step_cnt_d = step_cnt_q + {{(RATE_W-1){1'b0}}, 1'b1};
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      gate_prev_q <= 1'b0;
      phase_q     <= PH_IDLE;
      amp_q       <= {AMP_W{1'b0}};
      step_cnt_q  <= {RATE_W{1'b0}};
      attack_l_q  <= {RATE_W{1'b0}};
      decay_l_q   <= {RATE_W{1'b0}};
      sustain_l_q <= {AMP_W{1'b0}};
      rel_l_q     <= {RATE_W{1'b0}};
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      gate_prev_q <= gate_i;
      phase_q     <= phase_d;
      amp_q       <= amp_d;
      step_cnt_q  <= step_cnt_d;
      attack_l_q  <= attack_l_d;
      decay_l_q   <= decay_l_d;
      sustain_l_q <= sustain_l_d;
      rel_l_q     <= rel_l_d;
      active_q    <= (phase_d != PH_IDLE);
      done_q      <= done_d;
    end
  end

  assign amplitude_o = amp_q;
  assign phase_o     = phase_q;
  assign active_o    = active_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_adsr_gate_controller.sv
// -----------------------------------------------------------------------------
// tb_adsr_gate_controller
// Directed bench for the gated ADSR sequencer. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_adsr_gate_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        gate;
  logic [15:0] tick_div;
  logic [7:0]  attack, decay, sustain, rel;
  logic [7:0]  amplitude;
  logic [2:0]  phase;
  logic        active, done;

  int n_tests = 0;
  int n_fail  = 0;

  adsr_gate_controller dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .gate_i      (gate),
    .tick_div_i  (tick_div),
    .attack_i    (attack),
    .decay_i     (decay),
    .sustain_i   (sustain),
    .rel_i       (rel),
    .amplitude_o (amplitude),
    .phase_o     (phase),
    .active_o    (active),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int amp, input int ph,
                           input int act, input int dn);
    check_eq({tag, ".amp"},    {24'd0, amplitude}, amp);
    check_eq({tag, ".phase"},  {29'd0, phase},     ph);
    check_eq({tag, ".active"}, {31'd0, active},    act);
    check_eq({tag, ".done"},   {31'd0, done},      dn);
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gate  = 1'b0;
    clk_n(3);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; gate = 1'b1;
    tick_div = 16'd0; attack = 8'd0; decay = 8'd0; sustain = 8'd128; rel = 8'd1;

    // 1: reset held 3 clocks with gate high
    clk_n(3);
    check_out("t1_reset", 0, 0, 0, 0);
    reset = 1'b0; gate = 1'b0;
    clk_n(2);
    check_out("t1_idle", 0, 0, 0, 0);

    // 2: full attack, decay to 128, sustain
    gate = 1'b1;
    clk_n(1);   check_out("t2_rise", 0, 1, 1, 0);
    clk_n(254); check_out("t2_a254", 254, 1, 1, 0);
    clk_n(1);   check_out("t2_a255", 255, 2, 1, 0);
    clk_n(127); check_out("t2_d128", 128, 2, 1, 0);
    clk_n(1);   check_out("t2_sus", 128, 3, 1, 0);
    clk_n(6);   check_out("t2_hold", 128, 3, 1, 0);

    // 3: release with rel=1 (step every 2 clocks)
    gate = 1'b0;
    clk_n(1);   check_out("t3_fall", 128, 4, 1, 0);
    clk_n(1);   check_out("t3_r1", 128, 4, 1, 0);
    clk_n(1);   check_out("t3_r2", 127, 4, 1, 0);
    clk_n(253); check_out("t3_r255", 1, 4, 1, 0);
    clk_n(1);   check_out("t3_zero", 0, 4, 1, 0);
    clk_n(1);   check_out("t3_done", 0, 0, 0, 1);
    clk_n(1);   check_out("t3_after", 0, 0, 0, 0);

    // 4: tick_div=3, release from 40
    tick_div = 16'd3; attack = 8'd0; rel = 8'd0; sustain = 8'd128;
    do_reset();
    gate = 1'b1;
    clk_n(1);   check_out("t4_rise", 0, 1, 1, 0);
    clk_n(158); check_out("t4_a39", 39, 1, 1, 0);
    clk_n(1);   check_out("t4_a40", 40, 1, 1, 0);
    gate = 1'b0;
    clk_n(1);   check_out("t4_fall", 40, 4, 1, 0);
    clk_n(2);   check_out("t4_hold", 40, 4, 1, 0);
    clk_n(1);   check_out("t4_r39", 39, 4, 1, 0);
    clk_n(3);   check_out("t4_r39b", 39, 4, 1, 0);
    clk_n(1);   check_out("t4_r38", 38, 4, 1, 0);

    // 5: retrigger during release at 60, new attack rate latched
    tick_div = 16'd0; attack = 8'd0; decay = 8'd0; rel = 8'd0; sustain = 8'd128;
    do_reset();
    gate = 1'b1;
    clk_n(1);   check_out("t5_rise", 0, 1, 1, 0);
    clk_n(62);  check_out("t5_a62", 62, 1, 1, 0);
    gate = 1'b0;
    clk_n(1);   check_out("t5_fall", 62, 4, 1, 0);
    clk_n(2);   check_out("t5_r60", 60, 4, 1, 0);
    gate = 1'b1; attack = 8'd1; rel = 8'd5;
    clk_n(1);   check_out("t5_retrig", 60, 1, 1, 0);
    clk_n(1);   check_out("t5_hold60", 60, 1, 1, 0);
    clk_n(1);   check_out("t5_a61", 61, 1, 1, 0);
    clk_n(2);   check_out("t5_a62b", 62, 1, 1, 0);

    // 6a: sustain=255, DECAY lasts one clock
    attack = 8'd0; decay = 8'd0; rel = 8'd0; sustain = 8'd255;
    do_reset();
    gate = 1'b1;
    clk_n(256); check_out("t6_dec", 255, 2, 1, 0);
    clk_n(1);   check_out("t6_sus", 255, 3, 1, 0);
    clk_n(3);   check_out("t6_hold", 255, 3, 1, 0);

    // 6b: reset mid-DECAY
    sustain = 8'd128;
    do_reset();
    gate = 1'b1;
    clk_n(256); check_out("t6b_dec", 255, 2, 1, 0);
    clk_n(10);  check_out("t6b_d245", 245, 2, 1, 0);
    reset = 1'b1;
    clk_n(1);   check_out("t6b_rst", 0, 0, 0, 0);
    reset = 1'b0; gate = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk_n(1);
      check_out("t6b_nodone", 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
